// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the store-drain data cache.
//   state_t : receiver FSM states
//   line_t  : one cache line as seen on the array read port
//   get_idx / get_tag / get_off : split a 32-bit byte address into index, tag and word offset
package dcache_pkg;

  localparam int WORD_W    = 32;
  localparam int LINE_W    = 128;
  localparam int OFF_LSB   = 4;   // bytes per line = 16
  // Tags are stored zero-extended to the widest possible tag, so any legal
  // NUM_LINES shares one line_t layout.
  localparam int TAG_W_MAX = 32 - OFF_LSB;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL
  } state_t;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic                 valid;
    logic                 dirty;
    logic [LINE_W-1:0]    data;
  } line_t;

  function automatic int unsigned get_idx(input logic [31:0] addr, input int idx_w);
    return int'((addr >> OFF_LSB) & ((32'd1 << idx_w) - 32'd1));
  endfunction

  function automatic logic [TAG_W_MAX-1:0] get_tag(input logic [31:0] addr, input int idx_w);
    return TAG_W_MAX'(addr >> (OFF_LSB + idx_w));
  endfunction

  function automatic logic [1:0] get_off(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache.
//   clk, reset     : clock, async active-low reset (clears valid/dirty only)
//   rd_idx/rd_line : combinational read port
//   wr_idx         : line addressed by all write operations
//   wr_line_en     : install a full line (tag, data, valid=1, dirty=wr_line_dirty)
//   wr_word_en     : write one word at wr_word_off and set dirty
//   clr_dirty_en   : clear the dirty bit after a writeback
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx,
  output line_t                rd_line,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 wr_line_en,
  input  logic [TAG_W_MAX-1:0] wr_line_tag,
  input  logic [LINE_W-1:0]    wr_line_data,
  input  logic                 wr_line_dirty,
  input  logic                 wr_word_en,
  input  logic [1:0]           wr_word_off,
  input  logic [WORD_W-1:0]    wr_word_data,
  input  logic                 clr_dirty_en
);

  logic [TAG_W_MAX-1:0] tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // NOTE: tag and data storage carry no reset; valid gates every use of them,
  // and leaving them unreset lets them map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (wr_line_en) begin
      tag_mem[wr_idx]  <= wr_line_tag;
      data_mem[wr_idx] <= wr_line_data;
    end else if (wr_word_en) begin
      data_mem[wr_idx][{wr_word_off, 5'b0} +: WORD_W] <= wr_word_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_line_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_line_dirty;
    end else if (wr_word_en) begin
      dirty_q[wr_idx] <= 1'b1;
    end else if (clr_dirty_en) begin
      dirty_q[wr_idx] <= 1'b0;
    end
  end

  always_comb begin
    rd_line.tag   = tag_mem[rd_idx];
    rd_line.valid = valid_q[rd_idx];
    rd_line.dirty = dirty_q[rd_idx];
    rd_line.data  = data_mem[rd_idx];
  end

endmodule

// File: rtl/dcache_store_receiver.sv
// Receiving end of the store-buffer drain interface: captures one {addr,data}
// entry per handshake and writes the word into a direct-mapped, write-back,
// write-allocate cache, evicting a dirty victim and filling the line on a miss.
//   clk, reset            : clock, async active-low reset
//   sending_data_to_cache : store buffer offers an entry
//   data_to_cache         : [63:32] byte address, [31:0] store data
//   cache_ready_to_catch  : high only in IDLE; entry captured when both are high
//   store_done/store_hit  : one-cycle completion pulse and its hit/miss qualifier
//   mem_*                 : registered line request (writeback or fill) to memory
module dcache_store_receiver
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sending_data_to_cache,
  input  logic [63:0]                   data_to_cache,
  output logic                          cache_ready_to_catch,
  output logic                          store_done,
  output logic                          store_hit,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WORDS_PER_LINE*32-1:0]  mem_wdata,
  input  logic [WORDS_PER_LINE*32-1:0]  mem_rdata,
  input  logic                          mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);

  state_t               state;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_W-1:0]    data_q;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W_MAX-1:0] tag;
  logic [1:0]           off;
  line_t                rd_line;
  logic                 hit;
  logic [ADDR_W-1:0]    fill_addr;
  logic [ADDR_W-1:0]    victim_addr;
  logic [LINE_W-1:0]    merged_line;
  logic                 wr_line_en;
  logic                 wr_word_en;
  logic                 clr_dirty_en;

  assign idx         = IDX_W'(get_idx(32'(addr_q), IDX_W));
  assign tag         = get_tag(32'(addr_q), IDX_W);
  assign off         = get_off(32'(addr_q));
  assign hit         = rd_line.valid && (rd_line.tag == tag);
  assign fill_addr   = {addr_q[ADDR_W-1:OFF_LSB], 4'b0000};
  assign victim_addr = ADDR_W'({rd_line.tag, idx, 4'b0000});

  // Array write strobes follow the FSM state directly so the write lands on
  // the same edge that retires the state.
  assign wr_word_en   = (state == LOOKUP) && hit;
  assign wr_line_en   = (state == FILL) && mem_ready;
  assign clr_dirty_en = (state == WRITEBACK) && mem_ready;

  // Fill data with the pending store merged into its word slot.
  // NOTE: every always_comb output gets a full default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    merged_line = mem_rdata;
    merged_line[{off, 5'b0} +: WORD_W] = data_q;
  end

  dcache_line_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk           (clk),
    .reset         (reset),
    .rd_idx        (idx),
    .rd_line       (rd_line),
    .wr_idx        (idx),
    .wr_line_en    (wr_line_en),
    .wr_line_tag   (tag),
    .wr_line_data  (merged_line),
    .wr_line_dirty (1'b1),
    .wr_word_en    (wr_word_en),
    .wr_word_off   (off),
    .wr_word_data  (data_q),
    .clr_dirty_en  (clr_dirty_en)
  );

  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      addr_q               <= '0;
      data_q               <= '0;
      cache_ready_to_catch <= 1'b1;
      store_done           <= 1'b0;
      store_hit            <= 1'b0;
      mem_req              <= 1'b0;
      mem_we               <= 1'b0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
    end else begin
      store_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sending_data_to_cache && cache_ready_to_catch) begin
            addr_q               <= data_to_cache[32 +: ADDR_W];
            data_q               <= data_to_cache[31:0];
            cache_ready_to_catch <= 1'b0;
            state                <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            store_done           <= 1'b1;
            store_hit            <= 1'b1;
            cache_ready_to_catch <= 1'b1;
            state                <= IDLE;
          end else if (rd_line.valid && rd_line.dirty) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= victim_addr;
            mem_wdata <= rd_line.data;
            state     <= WRITEBACK;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
            state    <= FILL;
          end
        end
        WRITEBACK: begin
          // Request stays up across the switch to the fill.
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
            state    <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_req              <= 1'b0;
            store_done           <= 1'b1;
            store_hit            <= 1'b0;
            cache_ready_to_catch <= 1'b1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
